// File: rtl/fifo_param_buffer.sv
// Parametrised synchronous FIFO with internally generated pointers, occupancy
// count, threshold flags and registered overflow/underflow pulses.
module fifo_param_buffer #(
    parameter int WIDTH    = 15,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wen,
    input  logic                   ren,
    input  logic [WIDTH-1:0]       datain,
    output logic [WIDTH-1:0]       dataOut,
    output logic                   full,
    output logic                   empty,
    output logic                   almostFull,
    output logic                   almostEmpty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_ok, rd_ok;
    logic             full_w, empty_w;

    // All flags decode the registered count, so none has an input-to-output path.
    assign full_w      = (count_q == DEPTH_C);
    assign empty_w     = (count_q == '0);
    assign full        = full_w;
    assign empty       = empty_w;
    assign almostFull  = (count_q >= AF_C);
    assign almostEmpty = (count_q <= AE_C);
    assign count       = count_q;
    assign dataOut     = data_out_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    always_comb begin
        rd_ok       = ren && !empty_w;
        // A pop on a full FIFO frees the slot the simultaneous push reuses.
        wr_ok       = wen && (!full_w || rd_ok);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        overflow_d  = wen && !wr_ok;
        underflow_d = ren && !rd_ok;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + PW'(1);
            data_out_d = mem_q[rd_ptr_q];
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset; contents after reset are don't-care.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= datain;
        end
    end

endmodule

// File: tb/tb_fifo_param_buffer.sv
// Self-checking bench for fifo_param_buffer: a queue model of the FIFO feeds a
// scoreboard of expected read data, flags and counts come from per-test tables.
module tb_fifo_param_buffer;
    localparam int WIDTH = 15;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst, wen, ren;
    logic [WIDTH-1:0] datain, dataOut;
    logic             full, empty, almostFull, almostEmpty, overflow, underflow;
    logic [CW-1:0]    count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_out;
    logic [WIDTH-1:0] exp_d;
    logic             exp_ovf, exp_unf, exp_rd;

    always #5 clk = ~clk;

    fifo_param_buffer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(DEPTH - 1), .AE_LEVEL(1)
    ) dut (
        .clk(clk), .rst(rst), .wen(wen), .ren(ren), .datain(datain),
        .dataOut(dataOut), .full(full), .empty(empty), .almostFull(almostFull),
        .almostEmpty(almostEmpty), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    // Updates the reference queue, pushes expected read data, drives one edge.
    task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
        logic m_rd, m_wr;
        m_rd = r && (model_q.size() > 0);
        m_wr = w && ((model_q.size() < DEPTH) || m_rd);
        if (m_rd) exp_q.push_back(model_q.pop_front());
        if (m_wr) model_q.push_back(d);
        exp_ovf = w && !m_wr;
        exp_unf = r && !m_rd;
        exp_rd  = m_rd;
        wen = w; ren = r; datain = d;
        @(posedge clk); #1;
        wen = 1'b0; ren = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; wen = 1'b0; ren = 1'b0; datain = '0;
        model_q.delete(); exp_q.delete(); last_out = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
        n_checks++; if (count !== 4'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
        n_checks++; if (dataOut !== 15'd0) $display("FAIL reset_dataOut got %h want 0", dataOut); else n_pass++;
        n_checks++; if (almostEmpty !== 1'b1) $display("FAIL reset_almostEmpty got %b want 1", almostEmpty); else n_pass++;
        n_checks++; if (almostFull !== 1'b0) $display("FAIL reset_almostFull got %b want 0", almostFull); else n_pass++;
        n_checks++; if ({overflow, underflow} !== 2'b00) $display("FAIL reset_errors got %b want 00", {overflow, underflow}); else n_pass++;
    endtask

    task automatic test_basic;
        logic [WIDTH-1:0] vals [3];
        int exp_cnt [6];
        vals    = '{15'h1100, 15'd30001, 15'd32001};
        exp_cnt = '{1, 2, 3, 2, 1, 0};
        for (int i = 0; i < 6; i++) begin
            if (i < 3) step(1'b1, 1'b0, vals[i]); else step(1'b0, 1'b1, '0);
            n_checks++; if (count !== CW'(exp_cnt[i])) $display("FAIL basic_count[%0d] got %0d want %0d", i, count, exp_cnt[i]); else n_pass++;
            if (exp_rd) begin
                exp_d = exp_q.pop_front();
                n_checks++; if (dataOut !== exp_d) $display("FAIL basic_data[%0d] got %h want %h", i, dataOut, exp_d); else n_pass++;
                last_out = exp_d;
            end else begin
                n_checks++; if (dataOut !== last_out) $display("FAIL basic_hold[%0d] got %h want %h", i, dataOut, last_out); else n_pass++;
            end
        end
        n_checks++; if (empty !== 1'b1) $display("FAIL basic_empty got %b want 1", empty); else n_pass++;
    endtask

    task automatic test_fill_overflow;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, WIDTH'(i));
            n_checks++; if (count !== CW'(i + 1)) $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); else n_pass++;
            n_checks++; if (almostFull !== (i + 1 >= DEPTH - 1)) $display("FAIL fill_almostFull[%0d] got %b want %b", i, almostFull, (i + 1 >= DEPTH - 1)); else n_pass++;
            n_checks++; if (full !== (i == DEPTH - 1)) $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == DEPTH - 1)); else n_pass++;
        end
        step(1'b1, 1'b0, 15'h7FFF);
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_pulse got %b want 1", overflow); else n_pass++;
        n_checks++; if (overflow !== exp_ovf) $display("FAIL ovf_model got %b want %b", overflow, exp_ovf); else n_pass++;
        n_checks++; if (count !== 4'd8) $display("FAIL ovf_count got %0d want 8", count); else n_pass++;
        step(1'b0, 1'b0, '0);
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, '0);
            exp_d = exp_q.pop_front();
            n_checks++; if (dataOut !== exp_d || dataOut !== WIDTH'(i)) $display("FAIL drain_data[%0d] got %h want %h", i, dataOut, WIDTH'(i)); else n_pass++;
            last_out = exp_d;
        end
        n_checks++; if (empty !== 1'b1 || count !== 4'd0) $display("FAIL drain_empty got empty=%b count=%0d want 1/0", empty, count); else n_pass++;
    endtask

    task automatic test_full_rw;
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, WIDTH'(i));
        n_checks++; if (full !== 1'b1) $display("FAIL frw_full got %b want 1", full); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, WIDTH'(8 + i));
            exp_d = exp_q.pop_front();
            n_checks++; if (dataOut !== exp_d) $display("FAIL frw_data[%0d] got %h want %h", i, dataOut, exp_d); else n_pass++;
            n_checks++; if (count !== 4'd8) $display("FAIL frw_count[%0d] got %0d want 8", i, count); else n_pass++;
            n_checks++; if (overflow !== 1'b0) $display("FAIL frw_ovf[%0d] got %b want 0", i, overflow); else n_pass++;
            last_out = exp_d;
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, '0);
            exp_d = exp_q.pop_front();
            n_checks++; if (dataOut !== exp_d || dataOut !== WIDTH'(4 + i)) $display("FAIL wrap_data[%0d] got %h want %h", i, dataOut, WIDTH'(4 + i)); else n_pass++;
            last_out = exp_d;
        end
    endtask

    task automatic test_underflow;
        step(1'b0, 1'b1, '0);
        n_checks++; if (underflow !== exp_unf || underflow !== 1'b1) $display("FAIL unf_pulse got %b want 1", underflow); else n_pass++;
        n_checks++; if (dataOut !== last_out) $display("FAIL unf_hold got %h want %h", dataOut, last_out); else n_pass++;
        n_checks++; if (count !== 4'd0) $display("FAIL unf_count got %0d want 0", count); else n_pass++;
        step(1'b1, 1'b1, 15'h0ABC);
        n_checks++; if (underflow !== 1'b1) $display("FAIL unf_wr_pulse got %b want 1", underflow); else n_pass++;
        n_checks++; if (count !== 4'd1) $display("FAIL unf_wr_count got %0d want 1", count); else n_pass++;
        n_checks++; if (dataOut !== last_out) $display("FAIL unf_wr_hold got %h want %h", dataOut, last_out); else n_pass++;
        step(1'b0, 1'b1, '0);
        exp_d = exp_q.pop_front();
        n_checks++; if (dataOut !== exp_d || dataOut !== 15'h0ABC) $display("FAIL unf_read got %h want 0abc", dataOut); else n_pass++;
        n_checks++; if (underflow !== 1'b0) $display("FAIL unf_clear got %b want 0", underflow); else n_pass++;
        last_out = exp_d;
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, WIDTH'(16'h0100 + i));
        #2 rst = 1'b1;
        #1;
        n_checks++; if (count !== 4'd0) $display("FAIL arst_count got %0d want 0", count); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL arst_empty got %b want 1", empty); else n_pass++;
        n_checks++; if (dataOut !== 15'd0) $display("FAIL arst_dataOut got %h want 0", dataOut); else n_pass++;
        #4 rst = 1'b0;
        model_q.delete(); exp_q.delete(); last_out = '0;
        step(1'b1, 1'b0, 15'h1234);
        step(1'b0, 1'b1, '0);
        exp_d = exp_q.pop_front();
        n_checks++; if (dataOut !== exp_d || dataOut !== 15'h1234) $display("FAIL arst_read got %h want 1234", dataOut); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL arst_final_empty got %b want 1", empty); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_rw();
        test_underflow();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
